// File: rtl/nack_crc8_appender.sv
// rtl/nack_crc8_appender.sv - 16-bit stream stage that forwards a packet and appends a CRC8 trailer word
//
// ipbase_crc8_w16 : one-word CRC8 step (poly x^8+x^4+x^3+x^2+1, MSB first)
//   din  in  16  data word, bit 15 processed first
//   cyc  in   8  running remainder
//   dout out  8  next remainder
//
// nack_crc8_appender : packet pass-through with CRC8 trailer
//   clk      in   1  clock
//   rst      in   1  synchronous reset, active-high
//   s_valid  in   1  input word valid
//   s_ready  out  1  input word accepted when s_valid & s_ready
//   s_data   in  16  input word
//   s_last   in   1  final data word of the packet
//   m_valid  out  1  output word valid
//   m_ready  in   1  downstream accept
//   m_data   out 16  output word (data or trailer)
//   m_last   out  1  high only on the trailer word
//   crc_out  out  8  CRC of the last completed packet
//   err_len  out  1  one-cycle pulse when a packet runs past PKT_MAX words

module ipbase_crc8_w16 (
  input  logic [15:0] din,
  input  logic [7:0]  cyc,
  output logic [7:0]  dout
);

  logic [7:0] rem;
  logic       fb;

  // Bit-serial LFSR unrolled over the 16 data bits, MSB first.
  always_comb begin
    rem = cyc;
    fb  = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      fb  = rem[7] ^ din[i];
      rem = {rem[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
    end
    dout = rem;
  end

endmodule

module nack_crc8_appender #(
  parameter logic [7:0] CRC_INIT  = 8'h00,
  parameter int         TRAIL_POS = 0,
  parameter int         PKT_MAX   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic [7:0]  crc_out,
  output logic        err_len
);

  localparam int CW = $clog2(PKT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PKT_MAX);

  localparam logic [0:0] S_DATA  = 1'b0;
  localparam logic [0:0] S_TRAIL = 1'b1;

  logic [0:0]    state;
  logic [7:0]    remainder;
  logic [7:0]    crc_hold;
  logic [CW-1:0] word_cnt;
  logic [7:0]    crc_next;
  logic [15:0]   trailer;
  logic          out_free;
  logic          accept;

  ipbase_crc8_w16 u_crc_step (
    .din  (s_data),
    .cyc  (remainder),
    .dout (crc_next)
  );

  // The output register can take a new word when it is empty or being drained.
  assign out_free = !m_valid || m_ready;
  assign s_ready  = (state == S_DATA) && out_free;
  assign accept   = s_valid && s_ready;

  assign trailer = (TRAIL_POS == 0) ? {crc_hold, 8'h00} : {8'h00, crc_hold};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_DATA;
      remainder <= CRC_INIT;
      crc_hold  <= 8'h00;
      word_cnt  <= '0;
      m_valid   <= 1'b0;
      m_data    <= 16'h0000;
      m_last    <= 1'b0;
      crc_out   <= 8'h00;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        S_DATA: begin
          if (accept) begin
            m_valid   <= 1'b1;
            m_data    <= s_data;
            m_last    <= 1'b0;
            remainder <= crc_next;
            // A word arriving with the count already at PKT_MAX makes the
            // packet too long; it is still forwarded and folded into the CRC.
            if (word_cnt == CNT_MAX) begin
              err_len <= 1'b1;
            end else begin
              word_cnt <= word_cnt + CW'(1);
            end
            if (s_last) begin
              crc_hold <= crc_next;
              state    <= S_TRAIL;
            end
          end else if (m_ready) begin
            m_valid <= 1'b0;
          end
        end
        S_TRAIL: begin
          if (out_free) begin
            m_valid   <= 1'b1;
            m_data    <= trailer;
            m_last    <= 1'b1;
            crc_out   <= crc_hold;
            remainder <= CRC_INIT;
            word_cnt  <= '0;
            state     <= S_DATA;
          end
        end
        default: begin
          state <= S_DATA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nack_crc8_appender.sv
// tb/tb_nack_crc8_appender.sv - directed self-checking bench for nack_crc8_appender
module tb_nack_crc8_appender;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        m_ready;

  logic        s_ready,  s_ready2;
  logic        m_valid,  m_valid2;
  logic [15:0] m_data,   m_data2;
  logic        m_last,   m_last2;
  logic [7:0]  crc_out,  crc_out2;
  logic        err_len,  err_len2;

  int errors = 0;
  int checks = 0;

  nack_crc8_appender dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .crc_out(crc_out), .err_len(err_len)
  );

  // Lockstep twin with the alternate trailer layout and a tiny length limit.
  nack_crc8_appender #(.CRC_INIT(8'h00), .TRAIL_POS(1), .PKT_MAX(2)) dut2 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2),
    .crc_out(crc_out2), .err_len(err_len2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0; m_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data got=%h exp=0000", m_data); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    checks++; if (crc_out !== 8'h00) begin errors++; $display("FAIL reset_crc_out got=%h exp=00", crc_out); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len got=%b exp=0", err_len); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_single_word;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b1;
    tick;
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    checks++; if (m_data !== 16'h0001 || m_last !== 1'b0 || m_valid !== 1'b1) begin errors++; $display("FAIL single_data got=%h/%b/%b exp=0001/0/1", m_data, m_last, m_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL single_ready_trail got=%b exp=0", s_ready); end
    tick;
    checks++; if (m_data !== 16'h1D00 || m_last !== 1'b1) begin errors++; $display("FAIL single_trailer got=%h/%b exp=1D00/1", m_data, m_last); end
    checks++; if (crc_out !== 8'h1D) begin errors++; $display("FAIL single_crc got=%h exp=1D", crc_out); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after got=%b exp=1", s_ready); end
    tick;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", m_valid); end
  endtask

  task automatic test_msb_word;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h8000; s_last = 1'b1;
    tick;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_data !== 16'h8000) begin errors++; $display("FAIL msb_data got=%h exp=8000", m_data); end
    tick;
    checks++; if (m_data !== 16'hC900 || m_last !== 1'b1) begin errors++; $display("FAIL msb_trailer got=%h/%b exp=C900/1", m_data, m_last); end
    checks++; if (crc_out !== 8'hC9) begin errors++; $display("FAIL msb_crc got=%h exp=C9", crc_out); end
    checks++; if (m_data2 !== 16'h00C9 || m_last2 !== 1'b1) begin errors++; $display("FAIL msb_trailer_pos1 got=%h/%b exp=00C9/1", m_data2, m_last2); end
    tick;
  endtask

  task automatic test_two_word;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b0;
    tick;
    checks++; if (m_data !== 16'h0001 || m_last !== 1'b0) begin errors++; $display("FAIL two_w0 got=%h/%b exp=0001/0", m_data, m_last); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL two_ready_mid got=%b exp=1", s_ready); end
    s_data = 16'h0000; s_last = 1'b1;
    tick;
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    checks++; if (m_data !== 16'h0000 || m_last !== 1'b0) begin errors++; $display("FAIL two_w1 got=%h/%b exp=0000/0", m_data, m_last); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL two_ready_trail got=%b exp=0", s_ready); end
    tick;
    checks++; if (m_data !== 16'h8F00 || m_last !== 1'b1) begin errors++; $display("FAIL two_trailer got=%h/%b exp=8F00/1", m_data, m_last); end
    checks++; if (crc_out !== 8'h8F) begin errors++; $display("FAIL two_crc got=%h exp=8F", crc_out); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL two_ready_after got=%b exp=1", s_ready); end
    tick;
  endtask

  task automatic test_backpressure;
    logic [15:0] in_w [2];
    logic [15:0] exp_d [3];
    logic        exp_l [3];
    int in_idx;
    int out_cnt;
    logic prev_stall;
    logic [15:0] prev_data;
    in_w[0] = 16'h0001; in_w[1] = 16'h0000;
    exp_d[0] = 16'h0001; exp_d[1] = 16'h0000; exp_d[2] = 16'h8F00;
    exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b1;
    in_idx = 0;
    out_cnt = 0;
    for (int cyc = 0; cyc < 40 && out_cnt < 3; cyc++) begin
      m_ready = (cyc % 2 == 0);
      s_valid = (in_idx < 2);
      s_data  = (in_idx < 2) ? in_w[in_idx] : 16'h0000;
      s_last  = (in_idx == 1);
      #1;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== exp_d[out_cnt] || m_last !== exp_l[out_cnt]) begin
          errors++;
          $display("FAIL bp_out%0d got=%h/%b exp=%h/%b", out_cnt, m_data, m_last, exp_d[out_cnt], exp_l[out_cnt]);
        end
        out_cnt++;
      end
      if (s_valid && s_ready) in_idx++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick;
      if (prev_stall) begin
        checks++;
        if (m_data !== prev_data || m_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_stable got=%h/%b exp=%h/1", m_data, m_valid, prev_data);
        end
      end
    end
    checks++; if (out_cnt != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", out_cnt); end
    checks++; if (crc_out !== 8'h8F) begin errors++; $display("FAIL bp_crc got=%h exp=8F", crc_out); end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    tick; tick;
  endtask

  task automatic test_back_to_back;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b1;
    tick;
    checks++; if (m_data !== 16'h0001) begin errors++; $display("FAIL b2b_w0 got=%h exp=0001", m_data); end
    s_data = 16'h8000; s_last = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_trail got=%b exp=0", s_ready); end
    tick;
    checks++; if (m_data !== 16'h1D00 || m_last !== 1'b1) begin errors++; $display("FAIL b2b_trailer0 got=%h/%b exp=1D00/1", m_data, m_last); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_next got=%b exp=1", s_ready); end
    tick;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_data !== 16'h8000 || m_last !== 1'b0) begin errors++; $display("FAIL b2b_w1 got=%h/%b exp=8000/0", m_data, m_last); end
    tick;
    checks++; if (m_data !== 16'hC900 || m_last !== 1'b1) begin errors++; $display("FAIL b2b_trailer1 got=%h/%b exp=C900/1", m_data, m_last); end
    checks++; if (crc_out !== 8'hC9) begin errors++; $display("FAIL b2b_crc got=%h exp=C9", crc_out); end
    tick;
  endtask

  task automatic test_reset_mid_packet;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b0;
    tick;
    s_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0 || crc_out !== 8'h00) begin errors++; $display("FAIL rstmid_clear got=%b/%h exp=0/00", m_valid, crc_out); end
    tick;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_trailer got=%b exp=0", m_valid); end
    s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b1;
    tick;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_data !== 16'h0001 || m_last !== 1'b0) begin errors++; $display("FAIL rstmid_w0 got=%h/%b exp=0001/0", m_data, m_last); end
    tick;
    checks++; if (m_data !== 16'h1D00 || m_last !== 1'b1) begin errors++; $display("FAIL rstmid_trailer got=%h/%b exp=1D00/1", m_data, m_last); end
    tick;
  endtask

  task automatic test_len_error;
    logic [15:0] w [3];
    logic        exp_err [3];
    w[0] = 16'h0001; w[1] = 16'h0000; w[2] = 16'h0000;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0; exp_err[2] = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = w[i]; s_last = (i == 2);
      tick;
      checks++; if (err_len2 !== exp_err[i]) begin errors++; $display("FAIL len_err2_w%0d got=%b exp=%b", i, err_len2, exp_err[i]); end
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL len_err_main_w%0d got=%b exp=0", i, err_len); end
      checks++; if (m_data2 !== w[i]) begin errors++; $display("FAIL len_fwd_w%0d got=%h exp=%h", i, m_data2, w[i]); end
    end
    s_valid = 1'b0; s_last = 1'b0;
    tick;
    checks++; if (err_len2 !== 1'b0) begin errors++; $display("FAIL len_err_pulse got=%b exp=0", err_len2); end
    checks++; if (m_data !== 16'h6A00 || m_last !== 1'b1) begin errors++; $display("FAIL len_trailer got=%h/%b exp=6A00/1", m_data, m_last); end
    checks++; if (m_data2 !== 16'h006A || crc_out2 !== 8'h6A) begin errors++; $display("FAIL len_trailer2 got=%h/%h exp=006A/6A", m_data2, crc_out2); end
    tick;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0; m_ready = 1'b1;
    test_reset;
    test_single_word;
    test_msb_word;
    test_two_word;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_packet;
    test_len_error;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
